// File: rtl/bus_pkg.sv
// Shared types and constants for the single-master bus.
// Holds the FSM state encoding and the bus width.
package bus_pkg;

    localparam int BUS_W = 16;
    localparam logic [BUS_W-1:0] IDLE_ADDR_DEF = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STROBE,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    // States in which the latched request is presented on the bus.
    function automatic logic bus_active(state_t s);
        return (s == ST_WAIT) || (s == ST_STROBE) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/bus_master_if.sv
// Host request/response handshake and slave-side bus signals.
// The master modport faces the host and the slaves.
interface bus_master_if;
    import bus_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_rw;
    logic [BUS_W-1:0] req_addr;
    logic [BUS_W-1:0] req_wdata;
    logic             resp_valid;
    logic [BUS_W-1:0] resp_rdata;
    logic             resp_err;
    logic [BUS_W-1:0] addr_bus;
    logic [BUS_W-1:0] data_bus;
    logic             rw;
    logic             data_strobe;
    logic             address_valid;
    logic [BUS_W-1:0] data_bus_i;

    modport master (
        input  req_valid,
        input  req_rw,
        input  req_addr,
        input  req_wdata,
        input  address_valid,
        input  data_bus_i,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err,
        output addr_bus,
        output data_bus,
        output rw,
        output data_strobe
    );

    modport slave (
        output req_valid,
        output req_rw,
        output req_addr,
        output req_wdata,
        output address_valid,
        output data_bus_i,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err,
        input  addr_bus,
        input  data_bus,
        input  rw,
        input  data_strobe
    );

endinterface

// File: rtl/bus_master.sv
// Single-request bus master: decode wait with timeout, write strobe,
// read capture, and a one-cycle response pulse back to the host.
module bus_master
    import bus_pkg::*;
#(
    parameter int               TIMEOUT_CYCLES = 8,
    parameter logic [BUS_W-1:0] IDLE_ADDR      = IDLE_ADDR_DEF
) (
    input logic         clk,
    input logic         rst,
    bus_master_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BUS_W-1:0] addr_q, addr_d;
    logic [BUS_W-1:0] wdata_q, wdata_d;
    logic             rw_q, rw_d;
    logic [BUS_W-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= IDLE_ADDR;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_WAIT;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rw_d    = bus.req_rw;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (bus.address_valid) begin
                    state_d = rw_q ? ST_STROBE : ST_CAPTURE;
                end else if (cnt_q >= CNT_LAST) begin
                    // Nobody decoded the address: fail without strobing.
                    state_d = ST_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STROBE: begin
                state_d = ST_RESP;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            ST_CAPTURE: begin
                state_d = ST_RESP;
                rdata_d = bus.data_bus_i;
                err_d   = 1'b0;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign active = bus_active(state_q);

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.resp_valid  = (state_q == ST_RESP);
    assign bus.data_strobe = (state_q == ST_STROBE);
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;

    // Park the bus between transactions so stale decodes cannot carry over.
    assign bus.addr_bus = active ? addr_q  : IDLE_ADDR;
    assign bus.data_bus = active ? wdata_q : '0;
    assign bus.rw       = active & rw_q;

endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 SHALL provide parameters: TIMEOUT_CYCLES, default 8, max WAIT cycles before error; IDLE_ADDR, default 16'hFFFF, address no slave decodes.
REQ-002 SHALL provide clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL provide rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide req_valid  input  1  host request present.
REQ-005 SHALL provide req_ready  output  1  master can accept a request.
REQ-006 SHALL provide req_rw  input  1  1 = write, 0 = read.
REQ-007 SHALL provide req_addr  input  16  target address.
REQ-008 SHALL provide req_wdata  input  16  write data.
REQ-009 SHALL provide resp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL provide resp_rdata  output  16  read data; 0 for writes and errors.
REQ-011 SHALL provide resp_err  output  1  timeout flag, qualified by resp_valid.
REQ-012 SHALL provide addr_bus  output  16  bus address.
REQ-013 SHALL provide data_bus  output  16  bus write data.
REQ-014 SHALL provide rw  output  1  bus direction.
REQ-015 SHALL provide data_strobe  output  1  write strobe.
REQ-016 SHALL provide address_valid  input  1  slave decode ack, registered by slave.
REQ-017 SHALL provide data_bus_i  input  16  OR of slave read data, valid one cycle after address_valid is sampled high.

Function
REQ-018 SHALL implement states IDLE, WAIT, STROBE, CAPTURE, RESP.
REQ-019 SHALL assert req_ready only in IDLE; accept when req_valid and req_ready are both high at a clock edge.
REQ-020 SHALL, on accept, register req_addr, req_wdata and req_rw onto addr_bus, data_bus and rw, clear the timeout counter and enter WAIT.
REQ-021 SHALL hold addr_bus, data_bus and rw stable through WAIT, STROBE and CAPTURE.
REQ-022 SHALL drive addr_bus to IDLE_ADDR and rw, data_bus and data_strobe to 0 in IDLE and RESP.
REQ-023 SHALL, in WAIT with address_valid sampled high, go to STROBE if rw = 1 and to CAPTURE if rw = 0.
REQ-024 SHALL assert data_strobe for exactly one cycle, in STROBE only, then enter RESP with resp_err = 0 and resp_rdata = 0.
REQ-025 SHALL, in CAPTURE, register data_bus_i into resp_rdata and enter RESP with resp_err = 0.
REQ-026 SHALL increment the timeout counter each WAIT cycle without address_valid; on reaching TIMEOUT_CYCLES-1, enter RESP with resp_err = 1 and resp_rdata = 0, and assert no strobe.
REQ-027 SHALL size the timeout counter at $clog2(TIMEOUT_CYCLES)+1 bits and never let it wrap.
REQ-028 SHALL assert resp_valid for exactly one cycle, in RESP, then return to IDLE; resp_rdata and resp_err hold until the next RESP.
REQ-029 SHALL produce resp_valid 3 cycles after the accept edge for a slave with 1-cycle address_valid latency, for both read and write.
REQ-030 SHALL guarantee at least 2 cycles of IDLE_ADDR between transactions (RESP + IDLE), so address_valid from a prior transaction is never seen in the next WAIT.
REQ-031 SHALL ignore address_valid outside WAIT, and req_valid outside IDLE.

Reset
REQ-032 SHALL, while rst is high at a clock edge, enter IDLE and drive req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, addr_bus = IDLE_ADDR, data_bus = 0, rw = 0, data_strobe = 0, counter = 0.
REQ-033 SHALL abort any in-flight transaction on mid-operation reset with no resp_valid and no further strobe; a strobe asserted in the reset cycle is dropped at the next edge.

Structure
REQ-034 SHALL place the state enum, BUS_W = 16 and the IDLE_ADDR default in shared package bus_pkg.
REQ-035 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-036 Bench: instantiate bus_master with a RAM slave decoding address 20 and initialised to 99.
REQ-037 Scenario read: addr 20 -> resp_valid 3 cycles after accept, resp_rdata = 99, resp_err = 0.
REQ-038 Scenario write then read: write 16'h1234 to addr 20 -> data_strobe high exactly 1 cycle; a following read returns 16'h1234.
REQ-039 Scenario timeout: read addr 5 -> resp_valid with resp_err = 1 and resp_rdata = 0 after 8 WAIT cycles; data_strobe never high.
REQ-040 Scenario back-to-back: req_valid held high for two reads of addr 20 -> second accept occurs 2 cycles after the first resp_valid, and addr_bus = 16'hFFFF in between.
REQ-041 Scenario mid-operation reset: rst pulsed during STROBE of a write of 16'hBEEF -> no resp_valid, IDLE outputs next cycle, and a subsequent read returns the new or old value, matching the strobe edge.
